// File: rtl/rand_gen_arb.sv
// rand_gen_arb
// Shares one registered 32-bit xorshift128 generator among NREQ consumers.
// The block sequences the generator through reseed, warm-up discard and run,
// then hands out samples round-robin. The generator is stepped exactly once
// per grant, so no two consumers ever receive the same sample.
//
// Parameters:
//   NREQ  number of requesters (2..16)
//   WL_W  width of warmup_len
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   enable      1 = grant samples, 0 = hold generator and issue no grants
//   restart     one-cycle pulse: reseed the generator and re-run warm-up
//   warmup_len  generator steps discarded after each reseed
//   req         per-requester level request
//   gnt         one-hot grant pulse, dout is valid alongside it
//   dout        delivered sample
//   busy        high while reseeding or warming up
//   rng_rst     generator reset
//   rng_run     generator step enable
//   rng_out     generator output word
//   sample_cnt  delivered-sample count (0 unless counter is built)
//
// Build option:
//   RAND_GEN_ARB_CNT_EN  when defined, builds the 32-bit wrapping sample counter.

module rand_gen_arb #(
  parameter int NREQ = 4,
  parameter int WL_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            restart,
  input  logic [WL_W-1:0] warmup_len,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     dout,
  output logic            busy,
  output logic            rng_rst,
  output logic            rng_run,
  input  logic [31:0]     rng_out,
  output logic [31:0]     sample_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_RSTGEN,
    S_WARM,
    S_RUN,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WL_W-1:0] wc;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            any_req;
  logic            do_grant;
  logic [NREQ-1:0] winner_onehot;

  // Round-robin search: start just above the last winner and wrap, so the
  // most recently served requester is considered last.
  always_comb begin
    int idx;
    winner  = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[idx]) begin
        winner  = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;

  // Sequencing and grant decision. restart wins over everything so a reseed
  // never coincides with a delivered sample or a generator step.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    rng_run   = 1'b0;
    unique case (state)
      S_RSTGEN: begin
        state_nxt = (warmup_len != '0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        rng_run = 1'b1;
        if (wc == WL_W'(1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_nxt = S_HOLD;
        end else if (any_req) begin
          do_grant = 1'b1;
          rng_run  = 1'b1;
        end
      end
      S_HOLD: begin
        if (enable) state_nxt = S_RUN;
      end
    endcase
    if (restart) begin
      state_nxt = S_RSTGEN;
      do_grant  = 1'b0;
      rng_run   = 1'b0;
    end
  end

  // State, warm-up counter, pointer and registered grant/sample.
  // dout holds its last sample between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RSTGEN;
      wc    <= '0;
      ptr   <= PW'(NREQ - 1);
      gnt   <= '0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      if (do_grant) begin
        gnt  <= winner_onehot;
        dout <= rng_out;
        ptr  <= winner;
      end
      if (state == S_RSTGEN) begin
        wc <= warmup_len;
      end else if (state == S_WARM && wc != '0) begin
        wc <= wc - WL_W'(1);
      end
    end
  end

  assign rng_rst = rst | (state == S_RSTGEN);
  assign busy    = (state == S_RSTGEN) || (state == S_WARM);

`ifdef RAND_GEN_ARB_CNT_EN
  logic [31:0] cnt_q;

  // Counts cycles with a grant pulse; a clear beats an increment.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (|gnt) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign sample_cnt = cnt_q;
`else
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_rand_gen_arb.sv
// tb_rand_gen_arb
// Directed bench for rand_gen_arb. Contains a behavioural registered
// xorshift128 generator driven by rng_rst/rng_run, and an independent
// reference function giving the n-th output after a reseed.

module tb_rand_gen_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        restart;
  logic [15:0] warmup_len;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] dout;
  logic        busy;
  logic        rng_rst;
  logic        rng_run;
  logic [31:0] rng_out;
  logic [31:0] sample_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rand_gen_arb #(.NREQ(4), .WL_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .restart    (restart),
    .warmup_len (warmup_len),
    .req        (req),
    .gnt        (gnt),
    .dout       (dout),
    .busy       (busy),
    .rng_rst    (rng_rst),
    .rng_run    (rng_run),
    .rng_out    (rng_out),
    .sample_cnt (sample_cnt)
  );

  // Generator under the arbiter's control: registered state, output is w.
  logic [31:0] gx, gy, gz, gw, gt;
  always_ff @(posedge clk) begin
    if (rng_rst) begin
      gx <= 32'd123456789;
      gy <= 32'd362436069;
      gz <= 32'd521288629;
      gw <= 32'd88675123;
    end else if (rng_run) begin
      gx <= gy;
      gy <= gz;
      gz <= gw;
      gw <= gw ^ (gw >> 19) ^ (gt ^ (gt >> 8));
    end
  end
  assign gt      = gx ^ (gx << 11);
  assign rng_out = gw;

  // n-th generator output after a reseed (n=1 is the seed word w).
  function automatic logic [31:0] xs_nth(input int n);
    logic [31:0] x, y, z, w, t;
    x = 32'd123456789; y = 32'd362436069; z = 32'd521288629; w = 32'd88675123;
    for (int i = 1; i < n; i++) begin
      t = x ^ (x << 11);
      x = y; y = z; z = w;
      w = w ^ (w >> 19) ^ (t ^ (t >> 8));
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then release; the DUT is in RSTGEN afterwards.
  task automatic do_reset(input logic [15:0] wl);
    rst        = 1'b1;
    restart    = 1'b0;
    warmup_len = wl;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] prev;
    enable = 1'b1;
    req    = 4'b0001;
    rst    = 1'b1;
    restart = 1'b0;
    warmup_len = 16'd0;
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rst_gnt: got %b expected 0000", gnt); end
    tests_run++;
    if (dout !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_dout: got %h expected 00000000", dout); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b expected 1", busy); end
    tests_run++;
    if (rng_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_rng_run: got %b expected 0", rng_run); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (rng_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstgen_rng_rst: got %b expected 1", rng_rst); end
    tick();
    tests_run++;
    if (rng_run !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL run_entry: rng_run=%b busy=%b expected 1 0", rng_run, busy);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || dout !== 32'h05491333) begin
      tests_failed++; $display("[TB] FAIL first_sample: gnt=%b dout=%h expected 0001 05491333", gnt, dout);
    end
    prev = dout;
    for (int k = 2; k <= 6; k++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || dout !== xs_nth(k) || dout === prev) begin
        tests_failed++; $display("[TB] FAIL stream_%0d: gnt=%b dout=%h expected 0001 %h", k, gnt, dout, xs_nth(k));
      end
      prev = dout;
    end
  endtask

  task automatic test_warmup;
    req = 4'b0001;
    enable = 1'b1;
    do_reset(16'd4);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (busy !== 1'b1 || gnt !== 4'b0000) begin
        tests_failed++; $display("[TB] FAIL warm_busy_%0d: busy=%b gnt=%b expected 1 0000", c, busy, gnt);
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL warm_done: busy=%b expected 0", busy); end
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || dout !== xs_nth(5)) begin
      tests_failed++; $display("[TB] FAIL warm_first: gnt=%b dout=%h expected 0001 %h", gnt, dout, xs_nth(5));
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    enable = 1'b1;
    do_reset(16'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (gnt !== exp_g[k] || dout !== xs_nth(k + 1)) begin
        tests_failed++; $display("[TB] FAIL rr_%0d: gnt=%b dout=%h expected %b %h", k, gnt, dout, exp_g[k], xs_nth(k + 1));
      end
    end
  endtask

  task automatic test_enable_drop;
    req = 4'b1010;
    enable = 1'b1;
    do_reset(16'd0);
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || dout !== xs_nth(1)) begin
      tests_failed++; $display("[TB] FAIL en_pre1: gnt=%b dout=%h expected 0010 %h", gnt, dout, xs_nth(1));
    end
    tick();
    tests_run++;
    if (gnt !== 4'b1000 || dout !== xs_nth(2)) begin
      tests_failed++; $display("[TB] FAIL en_pre2: gnt=%b dout=%h expected 1000 %h", gnt, dout, xs_nth(2));
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (rng_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_hold_run_%0d: got %b expected 0", c, rng_run); end
      tick();
      tests_run++;
      if (gnt !== 4'b0000 || dout !== xs_nth(2)) begin
        tests_failed++; $display("[TB] FAIL en_frozen_%0d: gnt=%b dout=%h expected 0000 %h", c, gnt, dout, xs_nth(2));
      end
    end
    enable = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("[TB] FAIL en_resume_bubble: gnt=%b expected 0000", gnt); end
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || dout !== xs_nth(3)) begin
      tests_failed++; $display("[TB] FAIL en_resume1: gnt=%b dout=%h expected 0010 %h", gnt, dout, xs_nth(3));
    end
    tick();
    tests_run++;
    if (gnt !== 4'b1000 || dout !== xs_nth(4)) begin
      tests_failed++; $display("[TB] FAIL en_resume2: gnt=%b dout=%h expected 1000 %h", gnt, dout, xs_nth(4));
    end
  endtask

  task automatic test_idle;
    req = 4'b0000;
    enable = 1'b1;
    do_reset(16'd0);
    tick();
    tests_run++;
    if (rng_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_run: got %b expected 0", rng_run); end
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("[TB] FAIL idle_gnt: got %b expected 0000", gnt); end
    req = 4'b0100;
    #1;
    tests_run++;
    if (rng_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_req_run: got %b expected 1", rng_run); end
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || dout !== xs_nth(1)) begin
      tests_failed++; $display("[TB] FAIL idle_first: gnt=%b dout=%h expected 0100 %h", gnt, dout, xs_nth(1));
    end
  endtask

  task automatic test_restart;
    req = 4'b0001;
    enable = 1'b1;
    do_reset(16'd3);
    tick();
    tick();
    restart = 1'b1;
    warmup_len = 16'd0;
    #1;
    tests_run++;
    if (rng_run !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rs_warm_cycle: rng_run=%b busy=%b expected 0 1", rng_run, busy);
    end
    tick();
    restart = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || rng_rst !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rs_warm_after: gnt=%b rng_rst=%b expected 0000 1", gnt, rng_rst);
    end
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || dout !== 32'h05491333) begin
      tests_failed++; $display("[TB] FAIL rs_warm_first: gnt=%b dout=%h expected 0001 05491333", gnt, dout);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || dout !== xs_nth(2)) begin
      tests_failed++; $display("[TB] FAIL rs_run_pre: gnt=%b dout=%h expected 0001 %h", gnt, dout, xs_nth(2));
    end
    restart = 1'b1;
    #1;
    tests_run++;
    if (rng_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL rs_run_cycle: rng_run=%b expected 0", rng_run); end
    tick();
    restart = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || rng_rst !== 1'b1 || dout !== xs_nth(2)) begin
      tests_failed++; $display("[TB] FAIL rs_run_after: gnt=%b rng_rst=%b dout=%h expected 0000 1 %h", gnt, rng_rst, dout, xs_nth(2));
    end
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || dout !== 32'h05491333) begin
      tests_failed++; $display("[TB] FAIL rs_run_first: gnt=%b dout=%h expected 0001 05491333", gnt, dout);
    end
  endtask

  task automatic test_counter;
    req = 4'b0001;
    enable = 1'b1;
    do_reset(16'd0);
    tick();
    repeat (10) tick();
    req = 4'b0000;
    tick();
    tick();
`ifdef RAND_GEN_ARB_CNT_EN
    tests_run++;
    if (sample_cnt !== 32'd10) begin tests_failed++; $display("[TB] FAIL cnt_ten: got %0d expected 10", sample_cnt); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests_run++;
    if (sample_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL cnt_restart: got %0d expected 0", sample_cnt); end
    tick();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tests_run++;
    if (sample_cnt !== 32'hFFFF_FFFF || gnt !== 4'b0001) begin
      tests_failed++; $display("[TB] FAIL cnt_preload: cnt=%h gnt=%b expected ffffffff 0001", sample_cnt, gnt);
    end
    tick();
    tests_run++;
    if (sample_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL cnt_wrap: got %h expected 00000000", sample_cnt); end
`else
    tests_run++;
    if (sample_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL cnt_off: got %0d expected 0", sample_cnt); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests_run++;
    if (sample_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL cnt_off_restart: got %0d expected 0", sample_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    restart = 1'b0;
    warmup_len = 16'd0;
    req = 4'b0000;
    test_reset();
    test_warmup();
    test_round_robin();
    test_enable_drop();
    test_idle();
    test_restart();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rand_gen_arb.md
Name: rand_gen_arb

Overview:
- Scheduler and arbiter that shares one 32-bit xorshift128 uniform generator among NREQ consumers, e.g. noise injectors in the dummy simulator.
- Sequences the generator through reset, warm-up discard and run.
- Grants samples round-robin. Every delivered sample is distinct: the generator advances exactly once per grant.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WL_W, 16, width of warmup_len.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = grant samples; 0 = hold generator and issue no grants.
- restart  in  1  one-cycle pulse: reseed the generator and re-run warm-up.
- warmup_len  in  WL_W  number of generator steps discarded after a reseed.
- req  in  NREQ  per-requester sample request, level.
- gnt  out  NREQ  one-hot grant, one-cycle pulse; dout is valid with it.
- dout  out  32  delivered sample.
- busy  out  1  high in RSTGEN and WARM.
- rng_rst  out  1  drives the generator rst.
- rng_run  out  1  drives the generator run.
- rng_out  in  32  generator output (registered state word W).
- sample_cnt  out  32  count of delivered samples (see Optional Feature).

Behaviour:
- Reset values: gnt=0, dout=0, busy=1, rng_run=0, rr pointer=NREQ-1 (req[0] wins first), state=RSTGEN.
- rng_rst = rst OR (state==RSTGEN).
- Generator model: registered output; rng_run=1 at edge k makes rng_out show the next value after edge k.
- States:
  - RSTGEN: rng_rst=1 for one cycle. Latch warmup_len into the down-counter wc. Next state is WARM if wc!=0, else RUN.
  - WARM: rng_run=1 every cycle; wc decrements. When wc==1, next state is RUN, so exactly warmup_len steps are discarded. No grants.
  - RUN: if enable=0, next state is HOLD and no grant is issued this cycle. Otherwise, if any req bit is set, pick a winner by round-robin (search from pointer+1 upward, wrapping). Drive rng_run=1 combinationally. At the edge, register gnt<=onehot(winner), dout<=rng_out, pointer<=winner.
  - HOLD: rng_run=0, gnt=0, dout retains its value. Next state is RUN when enable=1.
- restart: from any state, next state is RSTGEN. It overrides any grant that cycle (gnt stays 0, rng_run=0). warmup_len is resampled.
- Latency:
  - gnt/dout appear 1 cycle after the req sample cycle.
  - Back-to-back grants every cycle are allowed; consecutive grants carry consecutive generator outputs.
- A requester that drops req before it is granted is simply skipped. There is no sample queueing.
- Idle RUN (req=0): rng_run=0, so the generator does not advance.
- busy=1 iff state is RSTGEN or WARM. Asserting rst mid-warm-up returns the block to RSTGEN.

Optional Feature:
- Macro: RAND_GEN_ARB_CNT_EN.
- Defined: sample_cnt is a 32-bit register.
  - Increments on each cycle with a gnt bit set.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst and restart (the clear takes priority over an increment in the same cycle).
- Not defined: sample_cnt is tied to 0 and no counter logic is built.

Test Plan:
- rst for 2 cycles, warmup_len=0, enable=1, req=4'b0001 held. Cycle after rst release: rng_rst=1. First gnt=0001 with dout=0x05491333 (88675123). Following cycles give xorshift128 outputs 2, 3, ... with no repeats.
- warmup_len=4, req=0001. busy=1 for 5 cycles after rst release (1 RSTGEN + 4 WARM). First dout = 5th model output (model seeded x=123456789, y=362436069, z=521288629, w=88675123).
- req=4'b1111 held in RUN. gnt sequence is 0001, 0010, 0100, 1000, 0001. dout values are consecutive model outputs.
- req=4'b1010 held, enable dropped for 3 cycles. gnt=0 and dout frozen during the drop. On resume, arbitration continues from the stored pointer with the next model output (no sample lost or duplicated).
- restart pulse during WARM, and separately during an active grant. No gnt in the restart cycle; rng_rst=1 the next cycle. The sequence restarts and the first dout again equals 0x05491333 (warmup_len=0).
- RAND_GEN_ARB_CNT_EN defined: 10 grants gives sample_cnt=10. Restart then gives 0. Preload via force to 0xFFFFFFFF plus one grant gives 0. Macro undefined: sample_cnt=0 throughout.
